pio_edge_capture_in: RTL and testbench

PIO_EDGE_CAPTURE_IN -- requirements
Module: pio_edge_capture_in

---
 rtl/pio_edge_capture_in_pkg.sv | 33 +++
 rtl/pio_edge_capture_in_if.sv | 35 +++
 rtl/pio_in_bit_cell.sv | 86 ++++++++
 rtl/pio_edge_capture_in.sv | 121 ++++++++++++
 tb/tb_pio_edge_capture_in.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pio_edge_capture_in_pkg.sv
// ---------------------------------------------------------------------------
// pio_in_pkg
// Shared constants for the edge-capturing parallel input port:
//   - Avalon-MM word offsets of the four registers
//   - capture-mode encodings for the EDGE_TYPE parameter
//   - edge_hit(): direction-qualified change detector used by each bit cell
// ---------------------------------------------------------------------------
package pio_in_pkg;

    // Register word offsets
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Capture modes
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // True when prev_v -> cur_v is a transition of the requested kind.
    // Any unknown mode value behaves as "any edge".
    function automatic logic edge_hit(input int mode, input logic prev_v, input logic cur_v);
        logic hit;
        case (mode)
            EDGE_RISE: hit = ~prev_v & cur_v;
            EDGE_FALL: hit = prev_v & ~cur_v;
            default:   hit = prev_v ^ cur_v;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pio_edge_capture_in_if.sv
// ---------------------------------------------------------------------------
// pio_edge_capture_in_if
// Avalon-MM slave bus bundle for pio_edge_capture_in.
//   address    [1:0]  word address
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata  [31:0] write data
//   readdata   [31:0] registered read data (driven by the slave)
// Modports: master (bus host / testbench), slave (the PIO).
// ---------------------------------------------------------------------------
interface pio_edge_capture_in_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/pio_in_bit_cell.sv
// ---------------------------------------------------------------------------
// pio_in_bit_cell
// One input bit of the PIO: synchroniser -> optional debouncer -> edge
// detector.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   in_bit        raw asynchronous input
//   armed         enables edge reporting once the pipeline holds only
//                 post-reset samples
//   stable        debounced (or one-flop delayed) synchronised value
//   edge_det      combinational edge flag, qualified by armed
// ---------------------------------------------------------------------------
module pio_in_bit_cell
    import pio_in_pkg::*;
#(
    parameter int EDGE_TYPE       = EDGE_RISE,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_bit,
    input  logic armed,
    output logic stable,
    output logic edge_det
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic                   stable_q;
    logic                   stable_prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable_q <= 1'b0;
                end else begin
                    stable_q <= sync_out;
                end
            end
        end else begin : g_debounce
            // The counter tracks how many consecutive cycles the synchronised
            // value has disagreed with stable_q; the Nth disagreeing cycle
            // commits the new value.
            localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);
            logic [15:0] cnt_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else if (sync_out == stable_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == LAST) begin
                    cnt_q    <= '0;
                    stable_q <= sync_out;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stable_prev_q <= 1'b0;
        end else begin
            stable_prev_q <= stable_q;
        end
    end

    assign stable   = stable_q;
    assign edge_det = armed & edge_hit(EDGE_TYPE, stable_prev_q, stable_q);

endmodule

// File: rtl/pio_edge_capture_in.sv
// ---------------------------------------------------------------------------
// pio_edge_capture_in
// Avalon-MM parallel input port with per-bit synchronisation, optional
// debouncing, edge capture and a masked level interrupt.
// Registers: 0 data (RO), 1 reserved (reads 0), 2 irq_mask (RW),
//            3 edge_capture (RO, write-1-to-clear, set wins over clear).
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   bus           Avalon-MM slave (address/chipselect/write_n/writedata/readdata)
//   in_port       WIDTH asynchronous inputs
//   irq           OR of (edge_capture & irq_mask)
// ---------------------------------------------------------------------------
module pio_edge_capture_in
    import pio_in_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int EDGE_TYPE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pio_edge_capture_in_if.slave    bus,
    input  logic [WIDTH-1:0]        in_port,
    output logic                    irq
);

    localparam logic [2:0] ARM_LIMIT = 3'(SYNC_STAGES + 1);

    logic [2:0]       arm_cnt_q;
    logic             armed_q;
    logic [WIDTH-1:0] data_stable;
    logic [WIDTH-1:0] edge_vec;
    logic [WIDTH-1:0] irq_mask_q;
    logic [WIDTH-1:0] edge_capture_q;
    logic [WIDTH-1:0] wr_data;
    logic             wr_en;
    logic [31:0]      rd_mux;

    // Arm counter: armed rises one cycle after the count completes, so the
    // first stable sample built purely from post-reset input has already
    // reached the history flop and cannot look like a fresh edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_cnt_q <= '0;
            armed_q   <= 1'b0;
        end else begin
            if (arm_cnt_q != ARM_LIMIT) begin
                arm_cnt_q <= arm_cnt_q + 3'd1;
            end
            armed_q <= (arm_cnt_q == ARM_LIMIT);
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            pio_in_bit_cell #(
                .EDGE_TYPE       (EDGE_TYPE),
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_cell (
                .clk      (clk),
                .reset_n  (reset_n),
                .in_bit   (in_port[i]),
                .armed    (armed_q),
                .stable   (data_stable[i]),
                .edge_det (edge_vec[i])
            );
        end

        if (WIDTH < 32) begin : g_unused_hi
            logic unused_writedata_hi;
            assign unused_writedata_hi = ^bus.writedata[31:WIDTH];
        end
    endgenerate

    assign wr_en   = bus.chipselect & ~bus.write_n;
    assign wr_data = bus.writedata[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
        end else if (wr_en && bus.address == ADDR_MASK) begin
            irq_mask_q <= wr_data;
        end
    end

    // New edges are OR-ed in after the clear so a coincident edge survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture_q <= '0;
        end else if (wr_en && bus.address == ADDR_EDGE) begin
            edge_capture_q <= (edge_capture_q & ~wr_data) | edge_vec;
        end else begin
            edge_capture_q <= edge_capture_q | edge_vec;
        end
    end

    // Read data is refreshed every cycle regardless of chipselect.
    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = data_stable;
            ADDR_RSVD: rd_mux = '0;
            ADDR_MASK: rd_mux[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_capture_q;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_pio_edge_capture_in.sv
// ---------------------------------------------------------------------------
// tb_pio_edge_capture_in
// Directed bench for pio_edge_capture_in. Three instances share clk/reset_n:
//   dut0  defaults (rising edge, no debounce)
//   dut1  DEBOUNCE_CYCLES = 8
//   dut2  EDGE_TYPE = any edge
// ---------------------------------------------------------------------------
module tb_pio_edge_capture_in;
    import pio_in_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [15:0] in0, in1, in2;
    logic        irq0, irq1, irq2;
    logic [31:0] rd;

    int tests_run    = 0;
    int tests_failed = 0;

    pio_edge_capture_in_if bus0 ();
    pio_edge_capture_in_if bus1 ();
    pio_edge_capture_in_if bus2 ();

    pio_edge_capture_in dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0),
        .in_port (in0),
        .irq     (irq0)
    );

    pio_edge_capture_in #(.DEBOUNCE_CYCLES(8)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus1),
        .in_port (in1),
        .irq     (irq1)
    );

    pio_edge_capture_in #(.EDGE_TYPE(EDGE_ANY)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2),
        .in_port (in2),
        .irq     (irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic [15:0] value);
        case (sel)
            0:       in0 = value;
            1:       in1 = value;
            default: in2 = value;
        endcase
    endtask

    task automatic busIdle(input int sel);
        case (sel)
            0: begin
                bus0.chipselect = 1'b0;
                bus0.write_n    = 1'b1;
            end
            1: begin
                bus1.chipselect = 1'b0;
                bus1.write_n    = 1'b1;
            end
            default: begin
                bus2.chipselect = 1'b0;
                bus2.write_n    = 1'b1;
            end
        endcase
    endtask

    task automatic busWrite(input int sel, input logic [1:0] addr, input logic [31:0] data);
        case (sel)
            0: begin
                bus0.address = addr; bus0.writedata = data;
                bus0.chipselect = 1'b1; bus0.write_n = 1'b0;
            end
            1: begin
                bus1.address = addr; bus1.writedata = data;
                bus1.chipselect = 1'b1; bus1.write_n = 1'b0;
            end
            default: begin
                bus2.address = addr; bus2.writedata = data;
                bus2.chipselect = 1'b1; bus2.write_n = 1'b0;
            end
        endcase
        tick();
        busIdle(sel);
    endtask

    // readdata is registered: present the address, let one edge pass, sample.
    task automatic busRead(input int sel, input logic [1:0] addr, output logic [31:0] data);
        case (sel)
            0:       bus0.address = addr;
            1:       bus1.address = addr;
            default: bus2.address = addr;
        endcase
        tick();
        case (sel)
            0:       data = bus0.readdata;
            1:       data = bus1.readdata;
            default: data = bus2.readdata;
        endcase
    endtask

    initial begin
        reset_n = 1'b0;
        in0 = '0; in1 = '0; in2 = '0;
        bus0.address = '0; bus0.writedata = '0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1;
        bus1.address = '0; bus1.writedata = '0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
        bus2.address = '0; bus2.writedata = '0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1;

        repeat (3) tick();
        checkOutput("reset_readdata0", bus0.readdata, 32'h0);
        checkOutput("reset_readdata1", bus1.readdata, 32'h0);
        checkOutput("reset_irq0", {31'h0, irq0}, 32'h0);
        checkOutput("reset_irq2", {31'h0, irq2}, 32'h0);

        reset_n = 1'b1;
        repeat (8) tick();

        // ---- dut0: basic capture, mask, irq, write-1-to-clear ----
        busWrite(0, ADDR_MASK, 32'h0000_0001);
        checkOutput("irq_before_edge", {31'h0, irq0}, 32'h0);
        applyStimulus(0, 16'h8001);
        repeat (6) tick();
        checkOutput("irq_on_bit0_rise", {31'h0, irq0}, 32'h1);
        busRead(0, ADDR_DATA, rd);
        checkOutput("data_8001", rd, 32'h0000_8001);
        busRead(0, ADDR_EDGE, rd);
        checkOutput("edge_8001", rd, 32'h0000_8001);
        busRead(0, ADDR_MASK, rd);
        checkOutput("mask_readback", rd, 32'h0000_0001);

        busWrite(0, ADDR_EDGE, 32'h0000_0001);
        checkOutput("irq_after_clear", {31'h0, irq0}, 32'h0);
        busRead(0, ADDR_EDGE, rd);
        checkOutput("edge_after_clear", rd, 32'h0000_8000);

        busWrite(0, ADDR_MASK, 32'hFFFF_FFFF);
        busRead(0, ADDR_MASK, rd);
        checkOutput("mask_upper_ignored", rd, 32'h0000_FFFF);
        busRead(0, ADDR_EDGE, rd);
        checkOutput("edge_kept_by_mask_write", rd, 32'h0000_8000);
        checkOutput("irq_bit15_masked_in", {31'h0, irq0}, 32'h1);
        busWrite(0, ADDR_MASK, 32'h0);
        busWrite(0, ADDR_EDGE, 32'hFFFF_FFFF);
        busRead(0, ADDR_EDGE, rd);
        checkOutput("edge_all_cleared", rd, 32'h0);

        // Falling edges are ignored in rising mode
        applyStimulus(0, 16'h0000);
        repeat (6) tick();
        busRead(0, ADDR_EDGE, rd);
        checkOutput("rise_mode_ignores_fall", rd, 32'h0);
        busRead(0, ADDR_DATA, rd);
        checkOutput("data_back_to_0", rd, 32'h0);

        // Set wins: the clear lands on the very edge that captures bit3
        applyStimulus(0, 16'h0008);
        repeat (3) tick();
        busWrite(0, ADDR_EDGE, 32'h0000_0008);
        repeat (2) tick();
        busRead(0, ADDR_EDGE, rd);
        checkOutput("set_wins_bit3", rd, 32'h0000_0008);
        busWrite(0, ADDR_EDGE, 32'h0000_0008);
        busRead(0, ADDR_EDGE, rd);
        checkOutput("clear_bit3_later", rd, 32'h0);
        busRead(0, ADDR_RSVD, rd);
        checkOutput("rsvd_reads_0_dut0", rd, 32'h0);

        // ---- dut1: debounce of 8 cycles on bit2 ----
        applyStimulus(1, 16'h0004);
        repeat (5) tick();
        applyStimulus(1, 16'h0000);
        repeat (6) tick();
        busRead(1, ADDR_DATA, rd);
        checkOutput("db_pulse5_data", rd, 32'h0);
        busRead(1, ADDR_EDGE, rd);
        checkOutput("db_pulse5_edge", rd, 32'h0);

        applyStimulus(1, 16'h0004);
        repeat (7) tick();
        applyStimulus(1, 16'h0000);
        repeat (6) tick();
        busRead(1, ADDR_DATA, rd);
        checkOutput("db_pulse7_data", rd, 32'h0);

        applyStimulus(1, 16'h0004);
        repeat (9) tick();
        busRead(1, ADDR_DATA, rd);
        checkOutput("db_hold_7th_cycle", rd, 32'h0);
        busRead(1, ADDR_DATA, rd);
        checkOutput("db_hold_8th_cycle", rd, 32'h0000_0004);
        busRead(1, ADDR_EDGE, rd);
        checkOutput("db_hold_edge", rd, 32'h0000_0004);

        // ---- dut2: any-edge mode on bit5 ----
        applyStimulus(2, 16'h0020);
        repeat (6) tick();
        busRead(2, ADDR_EDGE, rd);
        checkOutput("any_rise_bit5", rd, 32'h0000_0020);
        busWrite(2, ADDR_EDGE, 32'h0000_0020);
        busRead(2, ADDR_EDGE, rd);
        checkOutput("any_cleared", rd, 32'h0);
        applyStimulus(2, 16'h0000);
        repeat (6) tick();
        busRead(2, ADDR_EDGE, rd);
        checkOutput("any_fall_bit5", rd, 32'h0000_0020);
        busWrite(2, ADDR_RSVD, 32'hFFFF_FFFF);
        busRead(2, ADDR_RSVD, rd);
        checkOutput("any_rsvd_reads_0", rd, 32'h0);

        // ---- dut0: inputs high across reset release ----
        applyStimulus(1, 16'h0000);
        applyStimulus(0, 16'hFFFF);
        reset_n = 1'b0;
        repeat (3) tick();
        checkOutput("rst2_readdata0", bus0.readdata, 32'h0);
        checkOutput("rst2_irq0", {31'h0, irq0}, 32'h0);
        reset_n = 1'b1;
        repeat (10) tick();
        busRead(0, ADDR_EDGE, rd);
        checkOutput("held_high_no_edge", rd, 32'h0);
        busRead(0, ADDR_DATA, rd);
        checkOutput("held_high_data", rd, 32'h0000_FFFF);
        busRead(0, ADDR_MASK, rd);
        checkOutput("rst2_mask_cleared", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
